// File: rtl/subleq_pkg.sv
// subleq_pkg: shared state encoding and constants for the Subleq sequencer
package subleq_pkg;
    localparam int DEF_P_DATA = 8;
    localparam logic [DEF_P_DATA-1:0] DEF_HALT_ADDR = '1;
    localparam int INSTR_LEN = 3;
    typedef enum logic [2:0] {FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, EXEC, HALT} state_t;
endpackage

// File: rtl/subleq_sequencer_register.sv
// subleq_sequencer_register: write-enabled register cleared by synchronous reset
module subleq_sequencer_register #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // hold unless written; reset clears
    always_ff @(posedge clk)
        q <= rst ? '0 : we ? d : q;
endmodule

// File: rtl/subleq_sequencer.sv
// subleq_sequencer: fetch/operand/write-back sequencer for a Subleq CPU
module subleq_sequencer
    import subleq_pkg::*;
#(
    parameter int                P_DATA    = DEF_P_DATA,
    parameter logic [P_DATA-1:0] HALT_ADDR = {P_DATA{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [P_DATA-1:0] mem_addr,
    output logic              mem_re,
    input  logic [P_DATA-1:0] mem_rdata,
    output logic              mem_we,
    output logic [P_DATA-1:0] mem_wdata,
    output logic [P_DATA-1:0] pc,
    output logic              halted
);
    state_t state;
    logic [P_DATA-1:0] reg_a, reg_b, reg_c, op_a, res, pc_next;
    logic we_a, we_b, we_c, we_op, we_pc;

    assign res     = mem_rdata - op_a;
    assign pc_next = (res[P_DATA-1] || res == '0) ? reg_c : pc + P_DATA'(INSTR_LEN);
    assign we_a    = state == FETCH_B;
    assign we_b    = state == FETCH_C;
    assign we_c    = state == READ_A;
    assign we_op   = state == READ_B;
    assign we_pc   = state == EXEC;

    // memory strobes follow the state combinationally so rdata is consumed the cycle it arrives; rst forces them idle
    always_comb begin
        mem_re    = !rst && (state == FETCH_A ? run : state inside {FETCH_B, FETCH_C, READ_A, READ_B});
        mem_we    = !rst && state == EXEC;
        mem_wdata = mem_we ? res : '0;
        mem_addr  = rst                  ? '0 :
                    state == FETCH_B     ? pc + P_DATA'(1) :
                    state == FETCH_C     ? pc + P_DATA'(2) :
                    state == READ_A      ? reg_a :
                    state inside {READ_B, EXEC} ? reg_b :
                    state == FETCH_A     ? pc : '0;
    end

    // instruction sequencing; halting is decided from the pc about to be loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH_A;
            halted <= 1'b0;
        end else begin
            case (state)
                FETCH_A: state <= run ? FETCH_B : FETCH_A;
                FETCH_B: state <= FETCH_C;
                FETCH_C: state <= READ_A;
                READ_A:  state <= READ_B;
                READ_B:  state <= EXEC;
                EXEC: begin
                    state  <= pc_next == HALT_ADDR ? HALT : FETCH_A;
                    halted <= pc_next == HALT_ADDR;
                end
                default: state <= HALT;
            endcase
        end
    end

    subleq_sequencer_register #(.W(P_DATA)) u_reg_a (.clk(clk), .rst(rst), .we(we_a),  .d(mem_rdata), .q(reg_a));
    subleq_sequencer_register #(.W(P_DATA)) u_reg_b (.clk(clk), .rst(rst), .we(we_b),  .d(mem_rdata), .q(reg_b));
    subleq_sequencer_register #(.W(P_DATA)) u_reg_c (.clk(clk), .rst(rst), .we(we_c),  .d(mem_rdata), .q(reg_c));
    subleq_sequencer_register #(.W(P_DATA)) u_op_a  (.clk(clk), .rst(rst), .we(we_op), .d(mem_rdata), .q(op_a));
    subleq_sequencer_register #(.W(P_DATA)) u_pc    (.clk(clk), .rst(rst), .we(we_pc), .d(pc_next),   .q(pc));
endmodule
